// File: rtl/vx_alu_pe_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_alu_pe_sched_if : upstream issue and merged-result handshakes
// rev 1.0
// ---------------------------------------------------------------------------
interface vx_alu_pe_sched_if #(
  parameter int PE_COUNT = 3,
  parameter int DATAW    = 64
);
  localparam int SELW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [SELW-1:0]  req_pe_sel;
  logic [DATAW-1:0] req_data;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DATAW-1:0] rsp_data;
  logic [SELW-1:0]  rsp_pe;

  modport master (
    output req_valid, req_pe_sel, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_pe
  );

  modport slave (
    input  req_valid, req_pe_sel, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_pe
  );
endinterface
`default_nettype wire

// File: rtl/vx_alu_pe_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vx_alu_pe_sched : credit-gated issue fan-out and round-robin result merge
// rev 1.0
// ---------------------------------------------------------------------------
module vx_alu_pe_sched #(
  parameter int PE_COUNT     = 3,
  parameter int DATAW        = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_alu_pe_sched_if.slave          bus,
  output logic [PE_COUNT-1:0]       pe_req_valid,
  input  logic [PE_COUNT-1:0]       pe_req_ready,
  output logic [DATAW-1:0]          pe_req_data,
  input  logic [PE_COUNT-1:0]       pe_rsp_valid,
  output logic [PE_COUNT-1:0]       pe_rsp_ready,
  input  logic [PE_COUNT*DATAW-1:0] pe_rsp_data,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      busy,
  output logic                      sel_err
);
  localparam int SELW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam int CNTW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state;
  logic [CNTW-1:0]     cnt [PE_COUNT];
  logic [PE_COUNT-1:0] credit_ok;
  logic [PE_COUNT-1:0] req_fire;
  logic [PE_COUNT-1:0] rsp_fire;
  logic [PE_COUNT-1:0] grant;
  logic [SELW-1:0]     rr_ptr;
  logic [SELW-1:0]     win;
  logic [SELW-1:0]     hi_win;
  logic [SELW-1:0]     lo_win;
  logic [SELW-1:0]     rr_next;
  logic                hi_found;
  logic                any_grant;
  logic                out_free;
  logic                load;
  logic                run;
  logic                sel_ok;
  logic                ready_mux;
  logic                cnt_zero;
  logic                idle;
  logic [DATAW-1:0]    win_data;
  logic                out_valid;
  logic [DATAW-1:0]    out_data;
  logic [SELW-1:0]     out_pe;

  assign run    = (state == ST_RUN);
  assign sel_ok = int'(bus.req_pe_sel) < PE_COUNT;

  generate
    for (genvar i = 0; i < PE_COUNT; i++) begin : g_credit
      assign credit_ok[i] = cnt[i] < CNTW'(MAX_INFLIGHT);
      assign grant[i]     = any_grant && (win == SELW'(i));
    end
  endgenerate

  // An out-of-range select matches no PE, so it can neither issue nor be acknowledged.
  always_comb begin
    pe_req_valid = '0;
    ready_mux    = 1'b0;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (int'(bus.req_pe_sel) == i) begin
        pe_req_valid[i] = bus.req_valid && credit_ok[i] && run;
        ready_mux       = pe_req_ready[i] && credit_ok[i];
      end
    end
  end

  assign bus.req_ready = ready_mux && run;
  assign pe_req_data   = bus.req_data;
  assign req_fire      = pe_req_valid & pe_req_ready;

  // Descending scan leaves the lowest valid index overall and the lowest at/after rr_ptr.
  always_comb begin
    hi_found  = 1'b0;
    any_grant = 1'b0;
    hi_win    = '0;
    lo_win    = '0;
    for (int i = PE_COUNT - 1; i >= 0; i--) begin
      if (pe_rsp_valid[i]) begin
        any_grant = 1'b1;
        lo_win    = SELW'(i);
        if (SELW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_win   = SELW'(i);
        end
      end
    end
    win = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (grant[i]) win_data = pe_rsp_data[i*DATAW +: DATAW];
    end
  end

  assign rr_next      = (int'(win) == PE_COUNT - 1) ? '0 : win + 1'b1;
  assign out_free     = !out_valid || bus.rsp_ready;
  assign pe_rsp_ready = grant & {PE_COUNT{out_free}};
  assign rsp_fire     = pe_rsp_ready & pe_rsp_valid;
  assign load         = any_grant && out_free;

  always_comb begin
    cnt_zero = 1'b1;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (cnt[i] != '0) cnt_zero = 1'b0;
    end
  end

  assign idle = cnt_zero && !out_valid;
  assign busy = !idle;

  always_ff @(posedge clk) begin
    for (int i = 0; i < PE_COUNT; i++) begin
      if (!reset) begin
        cnt[i] <= '0;
      end else if (req_fire[i] && !rsp_fire[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (rsp_fire[i] && !req_fire[i]) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_RUN;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_pe     <= '0;
      rr_ptr     <= '0;
      drain_done <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      if (bus.req_valid && !sel_ok) sel_err <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_pe    <= win;
        rr_ptr    <= rr_next;
      end else if (bus.rsp_ready) begin
        out_valid <= 1'b0;
      end
      drain_done <= (state == ST_DRAIN) && idle;
      case (state)
        ST_RUN:   if (drain_req) state <= ST_DRAIN;
        ST_DRAIN: if (idle) state <= ST_DONE;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign bus.rsp_valid = out_valid;
  assign bus.rsp_data  = out_data;
  assign bus.rsp_pe    = out_pe;
endmodule
`default_nettype wire

// File: tb/tb_vx_alu_pe_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vx_alu_pe_sched : directed and random checks against a behavioural model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_vx_alu_pe_sched;
  localparam int PE_COUNT     = 3;
  localparam int DATAW        = 64;
  localparam int MAX_INFLIGHT = 4;
  localparam int SELW         = 2;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_alu_pe_sched_if #(.PE_COUNT(PE_COUNT), .DATAW(DATAW)) bus ();

  logic [PE_COUNT-1:0]       pe_req_valid, pe_req_ready, pe_rsp_valid, pe_rsp_ready;
  logic [DATAW-1:0]          pe_req_data;
  logic [PE_COUNT*DATAW-1:0] pe_rsp_data;
  logic                      drain_req, drain_done, busy, sel_err;
  logic [PE_COUNT-1:0]       rsp_want;

  vx_alu_pe_sched #(.PE_COUNT(PE_COUNT), .DATAW(DATAW), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .pe_req_valid(pe_req_valid), .pe_req_ready(pe_req_ready), .pe_req_data(pe_req_data),
    .pe_rsp_valid(pe_rsp_valid), .pe_rsp_ready(pe_rsp_ready), .pe_rsp_data(pe_rsp_data),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy), .sel_err(sel_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: outstanding ops per PE, one-entry result buffer, RR pointer, drain phase.
  int               m_cnt [PE_COUNT];
  bit               m_rv;
  logic [DATAW-1:0] m_rd;
  int               m_rp, m_rr, m_state;
  bit               m_done, m_err;
  bit               seen_ready;

  task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bitof(input logic [PE_COUNT-1:0] v, input int idx);
    return ((v >> idx) & PE_COUNT'(1)) != '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PE_COUNT; i++) m_cnt[i] = 0;
    m_rv = 0; m_rd = '0; m_rp = 0; m_rr = 0; m_state = M_RUN; m_done = 0; m_err = 0;
  endtask

  task automatic set_idle();
    bus.req_valid = 1'b0; bus.req_pe_sel = '0; bus.req_data = '0; bus.rsp_ready = 1'b1;
    pe_req_ready = '1; rsp_want = '0; drain_req = 1'b0;
    pe_rsp_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cycle();
    logic [PE_COUNT-1:0] e_pv, e_pr;
    bit               e_ready, idle, room;
    int               sel, win, idx, total;
    logic [DATAW-1:0] wd;
    // A PE only answers for work it holds (anything goes while reset is low).
    for (int i = 0; i < PE_COUNT; i++) pe_rsp_valid[i] = rsp_want[i] && (m_cnt[i] > 0 || !reset);
    #1;
    sel = int'(bus.req_pe_sel);
    e_pv = '0; e_ready = 0;
    if (sel < PE_COUNT && m_state == M_RUN && m_cnt[sel] < MAX_INFLIGHT) begin
      if (bus.req_valid) e_pv = PE_COUNT'(1) << sel;
      e_ready = bitof(pe_req_ready, sel);
    end
    win = -1;
    for (int k = 0; k < PE_COUNT; k++) begin
      idx = (m_rr + k) % PE_COUNT;
      if (win < 0 && bitof(pe_rsp_valid, idx)) win = idx;
    end
    room = !m_rv || bus.rsp_ready;
    e_pr = (win >= 0 && room) ? (PE_COUNT'(1) << win) : '0;
    chk("pe_req_valid", pe_req_valid, e_pv);
    chk("req_ready", bus.req_ready, e_ready);
    chk("pe_rsp_ready", pe_rsp_ready, e_pr);
    seen_ready = bus.req_ready;

    total = 0;
    for (int i = 0; i < PE_COUNT; i++) total += m_cnt[i];
    idle = (total == 0) && !m_rv;
    wd = (win >= 0) ? DATAW'(pe_rsp_data >> (win * DATAW)) : '0;
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < PE_COUNT; i++)
        m_cnt[i] = m_cnt[i] + int'(e_pv[i] && pe_req_ready[i]) - int'(e_pr[i]);
      if (bus.req_valid && sel >= PE_COUNT) m_err = 1;
      if (e_pr != '0) begin
        m_rv = 1; m_rd = wd; m_rp = win; m_rr = (win + 1) % PE_COUNT;
      end else if (bus.rsp_ready) begin
        m_rv = 0;
      end
      m_done = (m_state == M_DRAIN) && idle;
      case (m_state)
        M_RUN:   if (drain_req) m_state = M_DRAIN;
        M_DRAIN: if (idle) m_state = M_DONE;
        default: m_state = M_RUN;
      endcase
    end
    @(posedge clk);
    #1;
    total = 0;
    for (int i = 0; i < PE_COUNT; i++) total += m_cnt[i];
    chk("rsp_valid", bus.rsp_valid, m_rv);
    chk("rsp_data", bus.rsp_data, m_rd);
    chk("rsp_pe", bus.rsp_pe, m_rp);
    chk("busy", busy, (total != 0) || m_rv);
    chk("drain_done", drain_done, m_done);
    chk("sel_err", sel_err, m_err);
  endtask

  initial begin
    int acc, rr_exp [6];
    logic [DATAW-1:0] held, nd;
    bit seen;
    rr_exp = '{0, 1, 2, 0, 1, 2};

    // Reset: settle registers, then check combinational behaviour from the reset state.
    set_idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    bus.req_valid = 1'b1; pe_req_ready = 3'b001; rsp_want = 3'b001;
    cycle();
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_pe_rsp_ready0", pe_rsp_ready[0], 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_sel_err", sel_err, 1'b0);
    set_idle();
    reset = 1'b1;
    cycle();

    // Credit limit on PE1.
    acc = 0;
    bus.req_valid = 1'b1; bus.req_pe_sel = 2'd1;
    for (int n = 0; n < 6; n++) begin
      bus.req_data = {$urandom, $urandom};
      cycle();
      acc += int'(seen_ready);
      if (n == 4) chk("credit_5th_ready", seen_ready, 1'b0);
    end
    chk("credit_accepted", acc, 4);
    chk("credit_cnt1", dut.cnt[1], 4);
    chk("credit_busy", busy, 1'b1);

    // Two ops each on PE0 and PE2, then round-robin over all three.
    bus.req_pe_sel = 2'd0; cycle(); cycle();
    bus.req_pe_sel = 2'd2; cycle(); cycle();
    bus.req_valid = 1'b0;
    rsp_want = 3'b111;
    for (int n = 0; n < 6; n++) begin
      pe_rsp_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle();
      chk($sformatf("rr_valid%0d", n), bus.rsp_valid, 1'b1);
      chk($sformatf("rr_seq%0d", n), bus.rsp_pe, rr_exp[n]);
    end

    // Backpressure with the register full; PE1 still holds two results.
    bus.rsp_ready = 1'b0; rsp_want = 3'b010;
    held = bus.rsp_data;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_data_stable", bus.rsp_data, held);
      chk("bp_pe_rsp_ready", pe_rsp_ready, 3'b000);
    end
    nd = {$urandom, $urandom};
    pe_rsp_data[DATAW +: DATAW] = nd;
    bus.rsp_ready = 1'b1;
    cycle();
    chk("bp_reload_valid", bus.rsp_valid, 1'b1);
    chk("bp_reload_data", bus.rsp_data, nd);
    chk("bp_reload_pe", bus.rsp_pe, 1);
    repeat (3) cycle();
    rsp_want = '0;
    cycle();
    chk("bp_idle_busy", busy, 1'b0);

    // Simultaneous issue and result on PE0 at cnt=2.
    bus.req_valid = 1'b1; bus.req_pe_sel = 2'd0;
    cycle(); cycle();
    rsp_want = 3'b001;
    cycle();
    chk("simul_accept", seen_ready, 1'b1);
    chk("simul_cnt0", dut.cnt[0], 2);
    bus.req_valid = 1'b0;
    repeat (3) cycle();
    rsp_want = '0;

    // Drain while idle.
    drain_req = 1'b1;
    cycle();
    chk("idle_drain_t1", drain_done, 1'b0);
    drain_req = 1'b0;
    cycle();
    chk("idle_drain_t2", drain_done, 1'b1);
    cycle();
    chk("idle_drain_t3", drain_done, 1'b0);

    // Drain with two ops on PE2, the second issued alongside drain_req.
    bus.req_valid = 1'b1; bus.req_pe_sel = 2'd2;
    cycle();
    drain_req = 1'b1;
    cycle();
    chk("drain_same_cycle_accept", seen_ready, 1'b1);
    drain_req = 1'b0; bus.req_pe_sel = 2'd0;
    cycle();
    chk("drain_blocked", seen_ready, 1'b0);
    chk("drain_cnt2", dut.cnt[2], 2);
    rsp_want = 3'b100;
    seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      cycle();
      chk("drain_no_issue", seen_ready, 1'b0);
      seen = drain_done;
    end
    chk("drain_done_seen", seen, 1'b1);
    chk("drain_done_ready_low", bus.req_ready, 1'b0);
    cycle();
    chk("drain_resume_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b0; rsp_want = '0;
    cycle();

    // Invalid select, then reset mid-traffic.
    bus.req_valid = 1'b1; bus.req_pe_sel = 2'd3;
    cycle();
    chk("badsel_pe_req_valid", pe_req_valid, 3'b000);
    chk("badsel_req_ready", bus.req_ready, 1'b0);
    chk("badsel_sel_err", sel_err, 1'b1);
    bus.req_pe_sel = 2'd1;
    cycle(); cycle();
    bus.rsp_ready = 1'b0; rsp_want = 3'b010;
    cycle();
    reset = 1'b0;
    cycle();
    chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sel_err", sel_err, 1'b0);
    for (int i = 0; i < PE_COUNT; i++) chk($sformatf("midrst_cnt%0d", i), dut.cnt[i], 0);
    reset = 1'b1;
    set_idle();
    cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 199) != 0);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_pe_sel = ($urandom_range(0, 31) == 0) ? 2'd3 : SELW'($urandom_range(0, 2));
      bus.req_data  = {$urandom, $urandom};
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      pe_req_ready  = PE_COUNT'($urandom);
      rsp_want      = PE_COUNT'($urandom);
      pe_rsp_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drain_req     = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
